// File: rtl/i2c_deserializer.sv
// i2c_deserializer: receives I2C read-data bytes from the slave (MSB-first) into a 64-bit buffer.
// Ports: CLK/RST (async active-high); SCL_IN/SDA_IN raw pad lines; RX_EN read phase enable;
// CLEAR_RX clears buffer and flags; DATA_TO_CORE byte n at [8n+7:8n]; RX_BYTE_CNT bytes stored;
// BYTE_DONE byte strobe; ACK_SLOT awaiting 9th SCL rise; RX_FULL 8 bytes held; OVERRUN sticky.
module i2c_deserializer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  input  logic        RX_EN,
  input  logic        CLEAR_RX,
  output logic [63:0] DATA_TO_CORE,
  output logic [3:0]  RX_BYTE_CNT,
  output logic        BYTE_DONE,
  output logic        ACK_SLOT,
  output logic        RX_FULL,
  output logic        OVERRUN
);
  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;
  state_t state, state_nxt;
  logic [1:0] scl_sync, sda_sync;
  logic scl_prev, scl_rise, byte_end;
  logic [7:0] shift, byte_nxt;
  logic [2:0] bit_cnt;
  assign scl_rise = scl_sync[1] & ~scl_prev;
  assign byte_nxt = {shift[6:0], sda_sync[1]};
  // CLEAR_RX suppresses completion so no strobe or write happens in its cycle
  assign byte_end = (state == DATA) & RX_EN & scl_rise & (bit_cnt == 3'd7) & ~CLEAR_RX;
  assign RX_FULL = RX_BYTE_CNT == 4'd8;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = CLEAR_RX ? IDLE :
                (state == IDLE) ? (RX_EN ? DATA : IDLE) :
                !RX_EN ? IDLE :
                (state == DATA) ? (byte_end ? ACK : DATA) :
                (scl_rise ? DATA : ACK);
  always_comb ACK_SLOT = state == ACK;
  // synchronizers reset high (idle bus) so a rise needs SCL seen low first
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      scl_sync     <= 2'b11;
      sda_sync     <= 2'b11;
      scl_prev     <= 1'b1;
      shift        <= 8'd0;
      bit_cnt      <= 3'd0;
      DATA_TO_CORE <= 64'd0;
      RX_BYTE_CNT  <= 4'd0;
      BYTE_DONE    <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[0], SCL_IN};
      sda_sync  <= {sda_sync[0], SDA_IN};
      scl_prev  <= scl_sync[1];
      BYTE_DONE <= byte_end;
      if (CLEAR_RX) begin
        shift        <= 8'd0;
        bit_cnt      <= 3'd0;
        DATA_TO_CORE <= 64'd0;
        RX_BYTE_CNT  <= 4'd0;
        OVERRUN      <= 1'b0;
      end else begin
        if (state != DATA || !RX_EN) bit_cnt <= 3'd0;
        else if (scl_rise) begin
          shift   <= byte_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_end) begin
          if (RX_FULL) OVERRUN <= 1'b1;
          else begin
            DATA_TO_CORE[{RX_BYTE_CNT[2:0], 3'b000} +: 8] <= byte_nxt;
            RX_BYTE_CNT <= RX_BYTE_CNT + 4'd1;
          end
        end
      end
    end
endmodule
